// File: rtl/aes_rev_key_sched_if.sv
// Handshake bundle between key storage, the reverse key scheduler and the inverse-cipher round engine.
interface aes_rev_key_sched_if;
    logic         load_valid;
    logic         load_ready;
    logic [127:0] key_in;
    logic         abort;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_last;

    modport master (
        output load_valid, key_in, abort, rk_ready,
        input  load_ready, rk_valid, rk_out, rk_round, rk_last
    );

    modport slave (
        input  load_valid, key_in, abort, rk_ready,
        output load_ready, rk_valid, rk_out, rk_round, rk_last
    );
endinterface

// File: rtl/aes_rev_key_sched.sv
// AES-128 on-the-fly reverse key schedule: takes the round-10 key and walks back to round 0,
// one key per handshake, optionally presenting rounds 9..1 through InvMixColumns.
module aes_rev_key_sched #(
    parameter bit         EQ_INV    = 1'b1,
    parameter logic [7:0] RCON_LAST = 8'h36
) (
    input logic                clk,
    input logic                rst_n,
    aes_rev_key_sched_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [127:0] prev_key;
    logic [7:0]   rcon_div;
    logic         mix_en;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Forward sbox as GF(2^8) inverse (a^254) followed by the affine map, no lookup table.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Undo one forward expansion step; the current round's rcon is the one that built this key.
    always_comb begin
        {w0, w1, w2, w3} = key_q;
        p3       = w3 ^ w2;
        p2       = w2 ^ w1;
        p1       = w1 ^ w0;
        p0       = w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon_q, 24'h0};
        prev_key = {p0, p1, p2, p3};
        rcon_div = {1'b0, rcon_q[7:1]} ^ (rcon_q[0] ? 8'h8d : 8'h00);
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        if (state_q == IDLE) begin
            if (bus.load_valid) begin
                state_d = RUN;
                key_d   = bus.key_in;
                rcon_d  = RCON_LAST;
                round_d = 4'd10;
            end
        end else if (bus.abort) begin
            state_d = IDLE;
        end else if (bus.rk_ready) begin
            if (round_q == 4'd0) begin
                state_d = IDLE;
            end else begin
                key_d   = prev_key;
                rcon_d  = rcon_div;
                round_d = round_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            rcon_q  <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
        end
    end

    assign mix_en = EQ_INV && (round_q != 4'd0) && (round_q <= 4'd9);

    assign bus.load_ready = (state_q == IDLE);
    assign bus.rk_valid   = (state_q == RUN);
    assign bus.rk_round   = round_q;
    assign bus.rk_last    = (state_q == RUN) && (round_q == 4'd0);
    assign bus.rk_out     = mix_en ? {inv_mix_word(key_q[127:96]), inv_mix_word(key_q[95:64]),
                                      inv_mix_word(key_q[63:32]),  inv_mix_word(key_q[31:0])}
                                   : key_q;

endmodule

// File: tb/tb_aes_rev_key_sched.sv
// Bench for aes_rev_key_sched: raw (EQ_INV=0) and equivalent-inverse (EQ_INV=1) instances share stimulus;
// expected keys come from a forward FIPS-197 key expansion of a round-0 key.
module tb_aes_rev_key_sched;

    localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    // Rcon in force while round r is presented (index 0 unused).
    localparam logic [7:0] RCON_EXP [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    logic [127:0] exp_rk [11];

    aes_rev_key_sched_if bus0 ();
    aes_rev_key_sched_if bus1 ();

    assign bus1.load_valid = bus0.load_valid;
    assign bus1.key_in     = bus0.key_in;
    assign bus1.abort      = bus0.abort;
    assign bus1.rk_ready   = bus0.rk_ready;

    aes_rev_key_sched #(.EQ_INV(1'b0), .RCON_LAST(8'h36)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    aes_rev_key_sched #(.EQ_INV(1'b1), .RCON_LAST(8'h36)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mulc(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] a2, a4, a8;
        a2 = xt(a);
        a4 = xt(a2);
        a8 = xt(a4);
        case (c)
            8'h09:   return a8 ^ a;
            8'h0b:   return a8 ^ a2 ^ a;
            8'h0d:   return a8 ^ a4 ^ a;
            default: return a8 ^ a4 ^ a2;
        endcase
    endfunction

    function automatic logic [127:0] ref_imc(input logic [127:0] k);
        logic [127:0] o;
        logic [7:0]   b [4];
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) b[j] = k[127 - 32*c - 8*j -: 8];
            o[127 - 32*c -: 32] = {
                mulc(b[0],8'h0e) ^ mulc(b[1],8'h0b) ^ mulc(b[2],8'h0d) ^ mulc(b[3],8'h09),
                mulc(b[0],8'h09) ^ mulc(b[1],8'h0e) ^ mulc(b[2],8'h0b) ^ mulc(b[3],8'h0d),
                mulc(b[0],8'h0d) ^ mulc(b[1],8'h09) ^ mulc(b[2],8'h0e) ^ mulc(b[3],8'h0b),
                mulc(b[0],8'h0b) ^ mulc(b[1],8'h0d) ^ mulc(b[2],8'h09) ^ mulc(b[3],8'h0e)};
        end
        return o;
    endfunction

    // Forward FIPS-197 key expansion of a round-0 key into exp_rk[0..10].
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] exp_eq(input int r);
        return (r >= 1 && r <= 9) ? ref_imc(exp_rk[r]) : exp_rk[r];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full load-and-drain sequence with random backpressure and an optional stray load pulse.
    task automatic run_seq(input logic [127:0] k0, input int pct, input bit inject);
        int r;
        int cyc;
        bit rdy;
        expand(k0);
        bus0.load_valid = 1'b1;
        bus0.key_in     = exp_rk[10];
        step();
        bus0.load_valid = 1'b0;
        bus0.key_in     = {$urandom, $urandom, $urandom, $urandom};
        r   = 10;
        cyc = 0;
        while (r >= 0 && cyc < 300) begin
            chk("rk_valid", {127'd0, bus0.rk_valid}, 128'd1);
            chk("load_ready in RUN", {127'd0, bus0.load_ready}, 128'd0);
            chk($sformatf("rk_round0 r%0d", r), {124'd0, bus0.rk_round}, 128'(r));
            chk($sformatf("rk_round1 r%0d", r), {124'd0, bus1.rk_round}, 128'(r));
            chk($sformatf("rk_out raw r%0d", r), bus0.rk_out, exp_rk[r]);
            chk($sformatf("rk_out eq r%0d", r), bus1.rk_out, exp_eq(r));
            chk($sformatf("rk_last r%0d", r), {127'd0, bus0.rk_last}, {127'd0, (r == 0)});
            if (r > 0) chk($sformatf("rcon r%0d", r), {120'd0, u_dut0.rcon_q}, {120'd0, RCON_EXP[r]});
            rdy = ($urandom_range(0, 99) < pct);
            bus0.rk_ready = rdy;
            if (inject && cyc == 3) begin
                bus0.load_valid = 1'b1;
                bus0.key_in     = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
            bus0.load_valid = 1'b0;
            if (rdy) r--;
            cyc++;
        end
        bus0.rk_ready = 1'b0;
        chk("sequence complete", {127'd0, (r < 0)}, 128'd1);
        chk("rk_valid after last", {126'd0, bus0.rk_valid, bus1.rk_valid}, 128'd0);
        chk("load_ready after last", {127'd0, bus0.load_ready}, 128'd1);
    endtask

    typedef struct {
        int           round;
        logic [127:0] raw;
    } vec_t;

    initial begin
        vec_t         tab [4];
        logic [127:0] got0 [11];
        logic [127:0] got1 [11];
        logic         gotl [11];

        tab[0] = '{10, FIPS_K10};
        tab[1] = '{9,  128'hac7766f319fadc2128d12941575c006e};
        tab[2] = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
        tab[3] = '{0,  FIPS_K0};

        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus0.load_valid = 1'b0;
        bus0.key_in     = '0;
        bus0.abort      = 1'b0;
        bus0.rk_ready   = 1'b0;

        #12;
        chk("reset load_ready", {127'd0, bus0.load_ready}, 128'd1);
        chk("reset rk_valid", {126'd0, bus0.rk_valid, bus1.rk_valid}, 128'd0);
        chk("reset rk_last", {127'd0, bus0.rk_last}, 128'd0);
        chk("reset rk_round", {124'd0, bus0.rk_round}, 128'd0);
        chk("reset rk_out", bus1.rk_out, 128'd0);
        step();
        rst_n = 1'b1;
        step();

        // FIPS-197 A.1 with continuous ready, captured then compared against the table.
        bus0.load_valid = 1'b1;
        bus0.key_in     = FIPS_K10;
        bus0.rk_ready   = 1'b1;
        step();
        bus0.load_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("fips rk_round i%0d", i), {124'd0, bus0.rk_round}, 128'(10 - i));
            got0[10-i] = bus0.rk_out;
            got1[10-i] = bus1.rk_out;
            gotl[10-i] = bus0.rk_last;
            step();
        end
        bus0.rk_ready = 1'b0;
        chk("fips load_ready after", {127'd0, bus0.load_ready}, 128'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fips raw r%0d", tab[i].round), got0[tab[i].round], tab[i].raw);
            chk($sformatf("fips eq r%0d", tab[i].round), got1[tab[i].round],
                (tab[i].round >= 1 && tab[i].round <= 9) ? ref_imc(tab[i].raw) : tab[i].raw);
            chk($sformatf("fips last r%0d", tab[i].round), {127'd0, gotl[tab[i].round]},
                {127'd0, (tab[i].round == 0)});
        end

        run_seq(FIPS_K0, 100, 1'b0);
        run_seq(FIPS_K0, 50, 1'b0);

        // Abort at round 5 together with a handshake.
        bus0.load_valid = 1'b1;
        bus0.key_in     = FIPS_K10;
        bus0.rk_ready   = 1'b1;
        step();
        bus0.load_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("abort pre round", {124'd0, bus0.rk_round}, 128'd5);
        bus0.abort = 1'b1;
        step();
        bus0.abort    = 1'b0;
        bus0.rk_ready = 1'b0;
        chk("abort rk_valid", {126'd0, bus0.rk_valid, bus1.rk_valid}, 128'd0);
        chk("abort load_ready", {127'd0, bus0.load_ready}, 128'd1);
        run_seq(FIPS_K0, 100, 1'b0);

        // Abort in IDLE does not block a same-cycle load.
        bus0.abort      = 1'b1;
        bus0.load_valid = 1'b1;
        bus0.key_in     = FIPS_K10;
        step();
        bus0.abort      = 1'b0;
        bus0.load_valid = 1'b0;
        chk("idle abort load valid", {127'd0, bus0.rk_valid}, 128'd1);
        chk("idle abort load round", {124'd0, bus0.rk_round}, 128'd10);
        chk("idle abort load key", bus0.rk_out, FIPS_K10);
        bus0.abort = 1'b1;
        step();
        bus0.abort = 1'b0;
        chk("run abort rk_valid", {127'd0, bus0.rk_valid}, 128'd0);

        // Stray load during RUN with random backpressure.
        run_seq({$urandom, $urandom, $urandom, $urandom}, 60, 1'b1);

        // Asynchronous reset mid-sequence.
        bus0.load_valid = 1'b1;
        bus0.key_in     = FIPS_K10;
        bus0.rk_ready   = 1'b1;
        step();
        bus0.load_valid = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid reset rk_valid", {126'd0, bus0.rk_valid, bus1.rk_valid}, 128'd0);
        chk("mid reset load_ready", {127'd0, bus0.load_ready}, 128'd1);
        chk("mid reset rk_round", {124'd0, bus0.rk_round}, 128'd0);
        chk("mid reset rk_out", bus0.rk_out, 128'd0);
        chk("mid reset rk_last", {127'd0, bus1.rk_last}, 128'd0);
        bus0.rk_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        run_seq(FIPS_K0, 100, 1'b0);

        for (int n = 0; n < 5; n++) run_seq({$urandom, $urandom, $urandom, $urandom}, 50, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
